// File: rtl/bitcell_pkg.sv
// bitcell_pkg: shared definitions for the bitcell storage array.
//   state_e  - controller states (IDLE, RESP, CLEAR)
//   RW_READ / RW_WRITE - request opcode values on req_rw
package bitcell_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RESP,
      CLEAR
   } state_e;

   localparam logic RW_READ  = 1'b0;
   localparam logic RW_WRITE = 1'b1;

endpackage

// File: rtl/bitcell_word.sv
// bitcell_word: one WIDTH-bit storage row.
//   clk     - rising-edge clock
//   rst     - asynchronous active-high reset, row goes to 0
//   clr_i   - synchronous clear of the whole row (has priority over write)
//   we_i    - write enable
//   wmask_i - per-bit write enable, 1 = bit written
//   wdata_i - write data
//   rdata_o - stored row value
module bitcell_word #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr_i,
   input  logic             we_i,
   input  logic [WIDTH-1:0] wmask_i,
   input  logic [WIDTH-1:0] wdata_i,
   output logic [WIDTH-1:0] rdata_o
);

   logic [WIDTH-1:0] row_q;
   logic [WIDTH-1:0] row_d;

   always_comb begin
      row_d = row_q;
      if (clr_i) begin
         row_d = '0;
      end else if (we_i) begin
         // masked-off bits keep their stored value
         row_d = (row_q & ~wmask_i) | (wdata_i & wmask_i);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         row_q <= '0;
      end else begin
         row_q <= row_d;
      end
   end

   assign rdata_o = row_q;

endmodule

// File: rtl/bitcell_array.sv
// bitcell_array: DEPTH x WIDTH word-addressable storage with a valid/ready
// request port, registered read response, per-bit write mask and a
// sequenced clear sweep.
//   clk, rst              - clock, asynchronous active-high reset
//   req_valid/req_ready   - request handshake
//   req_rw                - 1 = write, 0 = read
//   req_addr              - word address (out-of-range: write dropped, read 0)
//   req_wdata/req_wmask   - write data and per-bit write enable
//   clr_start             - pulse to clear every word, one word per cycle
//   rsp_valid/rsp_ready   - read response handshake
//   rsp_rdata             - read data, held stable while rsp_valid
//   busy                  - clear sweep in progress
module bitcell_array
   import bitcell_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int DEPTH  = 16,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_rw,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [WIDTH-1:0]  req_wdata,
   input  logic [WIDTH-1:0]  req_wmask,
   input  logic              clr_start,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [WIDTH-1:0]  rsp_rdata,
   output logic              busy
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   state_e            state_q, state_d;
   logic              clr_pend_q, clr_pend_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0]  rdata_q, rdata_d;

   logic              accept;
   logic              wr_acc;
   logic              rd_acc;
   logic              sweep_last;
   logic [WIDTH-1:0]  rd_mux;
   logic [WIDTH-1:0]  row_data [DEPTH];

   assign accept     = req_valid & req_ready;
   assign wr_acc     = accept & (req_rw == RW_WRITE);
   assign rd_acc     = accept & (req_rw == RW_READ);
   assign sweep_last = (cnt_q == LAST_ADDR);

   // Storage rows; an address >= DEPTH matches no row, so writes there are
   // dropped without an explicit range check.
   for (genvar g = 0; g < DEPTH; g++) begin : g_row
      bitcell_word #(
         .WIDTH (WIDTH)
      ) u_word (
         .clk     (clk),
         .rst     (rst),
         .clr_i   (busy && (cnt_q == ADDR_W'(g))),
         .we_i    (wr_acc && (req_addr == ADDR_W'(g))),
         .wmask_i (req_wmask),
         .wdata_i (req_wdata),
         .rdata_o (row_data[g])
      );
   end

   // Read mux; out-of-range addresses fall through to zero.
   always_comb begin
      rd_mux = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (req_addr == ADDR_W'(i)) begin
            rd_mux = row_data[i];
         end
      end
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         clr_pend_q <= 1'b0;
         cnt_q      <= '0;
         rdata_q    <= '0;
      end else begin
         state_q    <= state_d;
         clr_pend_q <= clr_pend_d;
         cnt_q      <= cnt_d;
         rdata_q    <= rdata_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d    = state_q;
      clr_pend_d = clr_pend_q;
      cnt_d      = '0;
      rdata_d    = rdata_q;
      unique case (state_q)
         IDLE: begin
            if (clr_start) begin
               state_d = CLEAR;
            end else if (rd_acc) begin
               state_d = RESP;
               rdata_d = rd_mux;
            end
         end
         RESP: begin
            // a clear requested during the response waits until it is taken
            if (rsp_ready) begin
               state_d    = (clr_pend_q || clr_start) ? CLEAR : IDLE;
               clr_pend_d = 1'b0;
            end else if (clr_start) begin
               clr_pend_d = 1'b1;
            end
         end
         CLEAR: begin
            if (sweep_last) begin
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Outputs; clr_start in IDLE beats a concurrent request.
   always_comb begin
      req_ready = (state_q == IDLE) && !clr_start;
      rsp_valid = (state_q == RESP);
      busy      = (state_q == CLEAR);
      rsp_rdata = rdata_q;
   end

endmodule

// File: tb/tb_bitcell_array.sv
module tb_bitcell_array;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         sel = 1'b0;  // 0 = 16-deep DUT, 1 = 10-deep DUT
   logic         req_valid = 1'b0;
   logic         req_rw = 1'b0;
   logic [3:0]   req_addr = '0;
   logic [W-1:0] req_wdata = '0;
   logic [W-1:0] req_wmask = '0;
   logic         clr_start = 1'b0;
   logic         rsp_ready = 1'b0;

   logic         rdy16, vld16, busy16;
   logic [W-1:0] rd16;
   logic         rdy10, vld10, busy10;
   logic [W-1:0] rd10;

   logic         o_ready, o_valid, o_busy;
   logic [W-1:0] o_rdata;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   bitcell_array #(.WIDTH(W), .DEPTH(16)) u16 (
      .clk(clk), .rst(rst),
      .req_valid(req_valid & ~sel), .req_ready(rdy16), .req_rw(req_rw),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
      .clr_start(clr_start & ~sel),
      .rsp_valid(vld16), .rsp_ready(rsp_ready), .rsp_rdata(rd16), .busy(busy16)
   );

   bitcell_array #(.WIDTH(W), .DEPTH(10)) u10 (
      .clk(clk), .rst(rst),
      .req_valid(req_valid & sel), .req_ready(rdy10), .req_rw(req_rw),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
      .clr_start(clr_start & sel),
      .rsp_valid(vld10), .rsp_ready(rsp_ready), .rsp_rdata(rd10), .busy(busy10)
   );

   assign o_ready = sel ? rdy10  : rdy16;
   assign o_valid = sel ? vld10  : vld16;
   assign o_busy  = sel ? busy10 : busy16;
   assign o_rdata = sel ? rd10   : rd16;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Called just after a negedge; returns just after a later negedge.
   task automatic do_write(input logic [3:0] a, input logic [W-1:0] d, input logic [W-1:0] m);
      check("wr_ready", 32'(o_ready), 32'd1);
      req_valid = 1'b1; req_rw = 1'b1; req_addr = a; req_wdata = d; req_wmask = m;
      @(negedge clk);
      req_valid = 1'b0;
      check("wr_no_rsp", 32'(o_valid), 32'd0);
   endtask

   task automatic do_read(input string tag, input logic [3:0] a, input logic [W-1:0] exp);
      req_valid = 1'b1; req_rw = 1'b0; req_addr = a;
      @(negedge clk);
      req_valid = 1'b0;
      check({tag, "_valid"}, 32'(o_valid), 32'd1);
      check({tag, "_ready_low"}, 32'(o_ready), 32'd0);
      check(tag, 32'(o_rdata), 32'(exp));
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      check({tag, "_done"}, 32'(o_valid), 32'd0);
   endtask

   initial begin
      // ---------------- reset ----------------
      repeat (2) @(negedge clk);
      check("rst_ready", 32'(rdy16), 32'd1);
      check("rst_valid", 32'(vld16), 32'd0);
      check("rst_busy", 32'(busy16), 32'd0);
      check("rst_rdata", 32'(rd16), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      do_read("rd3_reset", 4'd3, 8'h00);
      check("post_rd_busy", 32'(o_busy), 32'd0);
      check("post_rd_ready", 32'(o_ready), 32'd1);

      // ---------------- DEPTH=10 out-of-range ----------------
      sel = 1'b1;
      for (int i = 0; i < 10; i++) do_write(4'(i), 8'(8'h10 + i), 8'hFF);
      do_write(4'd12, 8'h3C, 8'hFF);
      do_read("d10_rd12", 4'd12, 8'h00);
      for (int i = 0; i < 10; i++) do_read("d10_keep", 4'(i), 8'(8'h10 + i));
      sel = 1'b0;

      // ---------------- write / mask ----------------
      do_write(4'd5, 8'hA5, 8'hFF);
      do_read("rd5_full", 4'd5, 8'hA5);
      do_write(4'd5, 8'h0F, 8'hF0);
      do_read("rd5_mask", 4'd5, 8'h05);

      // ---------------- response stall ----------------
      do_write(4'd2, 8'h5A, 8'hFF);
      req_valid = 1'b1; req_rw = 1'b0; req_addr = 4'd2;
      @(negedge clk);
      // offer a write to addr 2 while the response is stalled
      req_rw = 1'b1; req_wdata = 8'hFF; req_wmask = 8'hFF;
      for (int i = 0; i < 4; i++) begin
         check("stall_valid", 32'(o_valid), 32'd1);
         check("stall_rdata", 32'(o_rdata), 32'h5A);
         check("stall_ready", 32'(o_ready), 32'd0);
         @(negedge clk);
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      do_read("stall_no_write", 4'd2, 8'h5A);

      // ---------------- clear pending during response ----------------
      req_valid = 1'b1; req_rw = 1'b0; req_addr = 4'd5;
      @(negedge clk);
      req_valid = 1'b0;
      clr_start = 1'b1;
      @(negedge clk);
      clr_start = 1'b0;
      check("pend_still_resp", 32'(o_valid), 32'd1);
      check("pend_not_busy", 32'(o_busy), 32'd0);
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      check("pend_busy", 32'(o_busy), 32'd1);
      repeat (16) @(negedge clk);
      check("pend_done", 32'(o_busy), 32'd0);
      do_read("pend_cleared", 4'd5, 8'h00);

      // ---------------- fill + clear wins over write ----------------
      for (int i = 0; i < 16; i++) do_write(4'(i), 8'hFF, 8'hFF);
      clr_start = 1'b1;
      req_valid = 1'b1; req_rw = 1'b1; req_addr = 4'd0; req_wdata = 8'h11; req_wmask = 8'hFF;
      #1 check("clr_ready_low", 32'(o_ready), 32'd0);
      @(negedge clk);
      clr_start = 1'b0; req_valid = 1'b0;
      for (int i = 0; i < 16; i++) begin
         check("clr_busy", 32'(o_busy), 32'd1);
         check("clr_busy_ready", 32'(o_ready), 32'd0);
         @(negedge clk);
      end
      check("clr_busy_end", 32'(o_busy), 32'd0);
      check("clr_ready_back", 32'(o_ready), 32'd1);
      for (int i = 0; i < 16; i++) do_read("clr_word", 4'(i), 8'h00);

      // ---------------- reset mid-sweep ----------------
      do_write(4'd9, 8'h77, 8'hFF);
      do_read("rd9_pre", 4'd9, 8'h77);
      clr_start = 1'b1;
      @(negedge clk);
      clr_start = 1'b0;
      repeat (7) @(negedge clk);  // sweep now on address 7
      check("mid_busy", 32'(o_busy), 32'd1);
      rst = 1'b1;
      #1;
      check("mrst_busy", 32'(o_busy), 32'd0);
      check("mrst_ready", 32'(o_ready), 32'd1);
      check("mrst_valid", 32'(o_valid), 32'd0);
      check("mrst_rdata", 32'(o_rdata), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("mrst_no_resume", 32'(o_busy), 32'd0);
      do_read("mrst_rd9", 4'd9, 8'h00);
      do_write(4'd4, 8'hC3, 8'hFF);
      do_read("mrst_rd4", 4'd4, 8'hC3);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
